// File: rtl/arm7tdmi_pkg.sv
// Shared constants and types for the ARM7TDMI core and its bench-side memory model.
package arm7tdmi_pkg;

   localparam logic [31:0] ARM_NOP    = 32'hE1A00000;
   localparam int          MEM_WAIT_W = 4;

   typedef enum logic {
      MEM_IDLE,
      MEM_WAIT
   } mem_state_t;

endpackage

// File: rtl/arm7_be_ram.sv
// Word array with async read, per-lane bus write and a priority backdoor write port.
module arm7_be_ram #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] FILL_WORD   = 32'hE1A00000,
   parameter int          AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wbe,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
);

   logic [31:0] mem [DEPTH_WORDS] = '{default: FILL_WORD};

   assign rdata = mem[raddr];

   // The backdoor assignment comes last so it overrides a bus write to the same word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int n = 0; n < 4; n++) begin
            if (wbe[n]) mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
         end
      end
      if (ld_en) mem[ld_addr] <= ld_data;
   end

endmodule

// File: rtl/arm7_wait_mem.sv
// Wait-state memory slave for the ARM7TDMI mem_* bus with a bench backdoor loader.
//
// state    | meaning
// MEM_IDLE | no access in flight; zero-wait accesses complete here
// MEM_WAIT | counting down wait cycles; completes when cnt reaches 0
module arm7_wait_mem
   import arm7tdmi_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RD_WAIT     = 2,
   parameter int          WR_WAIT     = 1,
   parameter logic [31:0] FILL_WORD   = ARM_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_be,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        mem_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [MEM_WAIT_W-1:0] RD_W = MEM_WAIT_W'(RD_WAIT);
   localparam logic [MEM_WAIT_W-1:0] WR_W = MEM_WAIT_W'(WR_WAIT);

   mem_state_t            state_q, state_d;
   logic [MEM_WAIT_W-1:0] cnt_q, cnt_d;
   logic                  rst_q;
   logic                  req, done, in_range, commit;
   logic [MEM_WAIT_W-1:0] wait_n;
   logic [31:0]           addr_hi, ram_rdata;
   logic                  unused_ld_hi;

   assign req      = mem_re | mem_we;
   assign wait_n   = mem_we ? WR_W : RD_W;
   assign addr_hi  = mem_addr >> (AW + 2);
   assign in_range = (addr_hi == 32'd0);
   assign unused_ld_hi = ^ld_addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (req) begin
               if (wait_n == '0) begin
                  done = 1'b1;
               end else begin
                  cnt_d   = wait_n - 1'b1;
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (!req) begin
               cnt_d   = '0;
               state_d = MEM_IDLE;
            end else if (cnt_q == '0) begin
               done    = 1'b1;
               state_d = MEM_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = MEM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Completion is masked during reset and the first cycle after it so the bus stays quiet.
   assign mem_ready = done & ~rst & ~rst_q;
   assign mem_err   = mem_ready & (~in_range | (mem_re & mem_we));
   assign mem_rdata = (mem_ready & in_range) ? ram_rdata : 32'd0;
   assign commit    = mem_ready & mem_we & in_range;

   arm7_be_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .FILL_WORD   (FILL_WORD),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .raddr   (mem_addr[AW+1:2]),
      .rdata   (ram_rdata),
      .we      (commit),
      .waddr   (mem_addr[AW+1:2]),
      .wdata   (mem_wdata),
      .wbe     (mem_be),
      .ld_en   (ld_en),
      .ld_addr (ld_addr[AW-1:0]),
      .ld_data (ld_data)
   );

endmodule

// File: tb/tb_arm7_wait_mem.sv
// Directed bench for arm7_wait_mem: one instance with RD_WAIT=2/WR_WAIT=1, one with RD_WAIT=0.
module tb_arm7_wait_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata, ld_addr, ld_data;
   logic [3:0]  be;
   logic        we, re, ready, err, ld_en;
   logic [31:0] b_addr, b_wdata, b_rdata, b_ld_addr, b_ld_data;
   logic [3:0]  b_be;
   logic        b_we, b_re, b_ready, b_err, b_ld_en;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   arm7_wait_mem #(.DEPTH_WORDS(4096), .RD_WAIT(2), .WR_WAIT(1), .FILL_WORD(32'hE1A00000)) dut (
      .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata), .mem_be(be),
      .mem_we(we), .mem_re(re), .mem_rdata(rdata), .mem_ready(ready), .mem_err(err),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   arm7_wait_mem #(.DEPTH_WORDS(4096), .RD_WAIT(0), .WR_WAIT(1), .FILL_WORD(32'hE1A00000)) dut0 (
      .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_be(b_be),
      .mem_we(b_we), .mem_re(b_re), .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err),
      .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled at the falling edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk_bus(input string tag, input logic r, input logic [31:0] d, input logic e);
      settle();
      chk({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
      chk({tag, "_rdata"}, rdata, d);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
   endtask

   initial begin
      rst = 1'b1; addr = 32'h0; wdata = 32'h0; be = 4'h0; we = 1'b0; re = 1'b1;
      ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
      b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0; b_we = 1'b0; b_re = 1'b0;
      b_ld_en = 1'b0; b_ld_addr = 32'h0; b_ld_data = 32'h0;
      #1;

      // reset with a read already presented
      chk_bus("rst_a", 1'b0, 32'h0, 1'b0);
      nxt();
      chk_bus("rst_b", 1'b0, 32'h0, 1'b0);
      nxt(); rst = 1'b0;

      // 1: read of word 0, RD_WAIT=2
      chk_bus("rd0_c0", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("rd0_c1", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("rd0_c2", 1'b1, 32'hE1A00000, 1'b0);
      nxt(); re = 1'b0;
      chk_bus("idle_after_rd", 1'b0, 32'h0, 1'b0);

      // 2: lane-masked write then read back
      nxt(); addr = 32'h10; wdata = 32'h12345678; be = 4'b0101; we = 1'b1;
      settle(); chk("wr_c0_ready", {31'd0, ready}, 32'd0);
      nxt(); settle(); chk("wr_c1_ready", {31'd0, ready}, 32'd1);
      chk("wr_c1_err", {31'd0, err}, 32'd0);
      nxt(); we = 1'b0; re = 1'b1; be = 4'h0;
      chk_bus("rb_c0", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("rb_c1", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("rb_c2", 1'b1, 32'hE1340078, 1'b0);
      nxt(); re = 1'b0;

      // 3: zero-wait back-to-back reads on the second instance
      for (int i = 0; i < 4; i++) begin
         b_ld_en = 1'b1; b_ld_addr = i; b_ld_data = i + 1;
         nxt();
      end
      b_ld_en = 1'b0; b_re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_addr = 4 * i;
         settle();
         chk($sformatf("z_rd%0d_ready", i), {31'd0, b_ready}, 32'd1);
         chk($sformatf("z_rd%0d_rdata", i), b_rdata, i + 1);
         nxt();
      end
      b_re = 1'b0;

      // 4: out-of-range read and write
      addr = 32'h4000; re = 1'b1;
      chk_bus("oor_rd_c0", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("oor_rd_c1", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("oor_rd_c2", 1'b1, 32'h0, 1'b1);
      nxt(); re = 1'b0;
      chk_bus("oor_after", 1'b0, 32'h0, 1'b0);
      nxt(); we = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
      settle(); chk("oor_wr_c0_ready", {31'd0, ready}, 32'd0);
      nxt(); settle(); chk("oor_wr_c1_ready", {31'd0, ready}, 32'd1);
      chk("oor_wr_c1_err", {31'd0, err}, 32'd1);
      nxt(); we = 1'b0; re = 1'b1; addr = 32'h0; be = 4'h0;
      nxt(); nxt(); chk_bus("oor_word0", 1'b1, 32'hE1A00000, 1'b0);
      nxt(); re = 1'b0;

      // 5a: read aborted in cycle 1, then a fresh read must take full latency
      nxt(); addr = 32'h10; re = 1'b1;
      settle(); chk("abort_c0_ready", {31'd0, ready}, 32'd0);
      nxt(); re = 1'b0;
      chk_bus("abort_c1", 1'b0, 32'h0, 1'b0);
      nxt(); re = 1'b1;
      chk_bus("reissue_c0", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("reissue_c1", 1'b0, 32'h0, 1'b0);
      nxt(); chk_bus("reissue_c2", 1'b1, 32'hE1340078, 1'b0);
      nxt(); re = 1'b0;

      // 5b: reset during the WAIT cycle of a write
      nxt(); we = 1'b1; wdata = 32'hDEADBEEF; be = 4'hF;
      settle(); chk("rstw_c0_ready", {31'd0, ready}, 32'd0);
      nxt(); rst = 1'b1;
      settle(); chk("rstw_c1_ready", {31'd0, ready}, 32'd0);
      nxt(); rst = 1'b0; we = 1'b0; be = 4'h0;
      settle(); chk("rstw_post_ready", {31'd0, ready}, 32'd0);
      nxt(); re = 1'b1;
      nxt(); nxt(); chk_bus("rstw_word", 1'b1, 32'hE1340078, 1'b0);
      nxt(); re = 1'b0;

      // 6a: backdoor collides with a committing bus write
      nxt(); we = 1'b1; wdata = 32'hAAAAAAAA; be = 4'hF;
      nxt(); ld_en = 1'b1; ld_addr = 32'd4; ld_data = 32'h55667788;
      settle(); chk("coll_ready", {31'd0, ready}, 32'd1);
      nxt(); ld_en = 1'b0; we = 1'b0; be = 4'h0; re = 1'b1;
      nxt(); nxt(); ld_en = 1'b1; ld_data = 32'h01020304;
      chk_bus("coll_word", 1'b1, 32'h55667788, 1'b0);
      nxt(); ld_en = 1'b0;
      nxt(); nxt(); chk_bus("ld_new_word", 1'b1, 32'h01020304, 1'b0);
      nxt(); re = 1'b0;

      // 6b: simultaneous read and write is a write reporting an error
      nxt(); addr = 32'h20; wdata = 32'h0BADF00D; be = 4'hF; we = 1'b1; re = 1'b1;
      settle(); chk("rw_c0_ready", {31'd0, ready}, 32'd0);
      nxt(); settle(); chk("rw_c1_ready", {31'd0, ready}, 32'd1);
      chk("rw_c1_err", {31'd0, err}, 32'd1);
      nxt(); we = 1'b0; be = 4'h0;
      nxt(); nxt(); chk_bus("rw_word", 1'b1, 32'h0BADF00D, 1'b0);
      nxt(); re = 1'b0;
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arm7_wait_mem.md
Name: arm7_wait_mem

Overview:
Word-organised memory slave that sits directly upstream of arm7tdmi_top and answers its mem_* bus (addr/wdata/rdata/we/re/be/ready).
It inserts a programmable number of wait states per access, so fetch/decode stalling is exercised instead of the always-ready case.
It is used in every core bench as the single instruction+data memory.
A bench-side backdoor port preloads programs.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words (power of two)
RD_WAIT, 2, wait cycles inserted before a read completes (0..15)
WR_WAIT, 1, wait cycles inserted before a write completes (0..15)
FILL_WORD, 32'hE1A00000, time-zero content of every word (MOV R0,R0)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
mem_addr  in  32  byte address from core
mem_wdata  in  32  write data
mem_be  in  4  byte-lane enables, bit n = bits [8n+7:8n]
mem_we  in  1  write request
mem_re  in  1  read request
mem_rdata  out  32  read data, valid only while mem_ready & mem_re
mem_ready  out  1  access completes this cycle
mem_err  out  1  access error, valid only with mem_ready
ld_en  in  1  backdoor word write
ld_addr  in  32  backdoor word index
ld_data  in  32  backdoor data

Behaviour:
- Reset: clk and rst as above (one clock; synchronous, active-high reset). While rst=1 and on the cycle after it drops: state=IDLE, wait counter=0, mem_ready=0, mem_err=0, mem_rdata=0. Array contents are NOT affected by rst; the array is FILL_WORD at time zero.
- req = mem_re | mem_we. If both are high, the access is a write and mem_err=1 on completion.
- Word index = mem_addr[31:2]; addr[1:0] is ignored. Lane selection comes only from mem_be.
- Out of range (mem_addr >= 4*DEPTH_WORDS): completes with normal latency, rdata=0, write dropped, mem_err=1.
- The core holds addr/wdata/be/we/re stable until it samples mem_ready=1.
- FSM states IDLE and WAIT. W = WR_WAIT if mem_we, else RD_WAIT.
  - IDLE, req, W=0: mem_ready=1 combinationally in the same cycle; stay in IDLE.
  - IDLE, req, W>0: load cnt=W-1 and go to WAIT; mem_ready=0.
  - WAIT, cnt>0: decrement cnt.
  - WAIT, cnt=0: mem_ready=1, then go to IDLE.
  - WAIT, req dropped: abort, go to IDLE, no write, no ready.
- Latency: a request first seen in cycle 0 gets mem_ready in cycle W. With W=0, back-to-back accesses complete every cycle. With W>0, each access takes W+1 cycles, with no idle bubble between accesses.
- Read data: mem_rdata = array[index] combinationally during the ready cycle. It is 0 in all other cycles, for deterministic waveforms.
- Write commit: at the rising edge that ends the ready cycle, each lane with be[n]=1 is updated. be=0 is a legal no-op write that still completes.
- Backdoor: ld_en writes ld_data to array[ld_addr mod DEPTH_WORDS] on the clock edge, independent of FSM state.
  - If it targets the same word as a committing bus write in the same cycle, the backdoor wins for all lanes.
  - A read completing in the cycle of the backdoor write returns the old value.
- rst asserted mid-WAIT: the access is discarded with no write. The core must reissue it.

Decomposition:
- arm7tdmi_pkg gets: ARM_NOP constant (32'hE1A00000), typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t, and the wait-counter width constant MEM_WAIT_W=4.
- One sub-module, arm7_be_ram: a DEPTH_WORDS x 32 array with async read, per-lane synchronous write, and a second write port for backdoor with priority. The FSM and counter stay in arm7_wait_mem.

Test Plan:
1. RD_WAIT=2, after rst: read addr 0x0 held -> mem_ready low for cycles 0-1, high in cycle 2 with rdata=0xE1A00000, err=0.
2. WR_WAIT=1: write 0x12345678 to 0x10 with be=4'b0101, then read 0x10 -> ready on the 2nd cycle of the write; read returns 0xE1340078.
3. RD_WAIT=0: 4 consecutive reads at 0x0, 0x4, 0x8, 0xC (backdoor-loaded 1,2,3,4) -> mem_ready=1 every cycle; rdata 1,2,3,4 in order.
4. Read 4*DEPTH_WORDS (0x4000) -> normal latency, rdata=0, mem_err=1 for one cycle. A write there leaves all words unchanged.
5. Abort and reset: a read with re dropped in cycle 1 -> no ready, FSM back in IDLE. A write with rst pulsed mid-WAIT -> target word keeps its old value; mem_ready=0 through reset.
6. Backdoor ld_en to word 4 in the same cycle a bus write to 0x10 commits -> word 4 = ld_data; simultaneous re+we -> write performed, mem_err=1.
